// File: rtl/cache_drain_merger.sv
// Drains a cache's hash/occurrence table and merges it into a local frequency table.
// Several passes, one per processor cache, build the global result behind a registered read port.
module cache_drain_merger #(
    parameter int DATA_INDEX_WIDTH            = 32,
    parameter int BIT_ON_TAILS                = 7,
    parameter int LENGTH_HASH_ARRAY_WIDTH_BIT = $clog2(1 << (BIT_ON_TAILS + 1)),
    parameter int COLL_CNT_WIDTH              = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   clear,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   DataRequest,
    input  logic                                   CacheEnough,
    input  logic                                   WrHashNext,
    input  logic [LENGTH_HASH_ARRAY_WIDTH_BIT-1:0] AddrHashOccurrNext,
    input  logic [2*DATA_INDEX_WIDTH-1:0]          HashOccurrNext,
    input  logic [BIT_ON_TAILS-1:0]                RdAddr,
    output logic [DATA_INDEX_WIDTH-1:0]            RdHash,
    output logic [DATA_INDEX_WIDTH-1:0]            RdOccurr,
    output logic [COLL_CNT_WIDTH-1:0]              CollisionCount,
    output logic                                   AddrError
);

    localparam int LENGTH_HASH_ARRAY = 1 << BIT_ON_TAILS;
    localparam logic [LENGTH_HASH_ARRAY_WIDTH_BIT-1:0] MAX_ADDR =
        LENGTH_HASH_ARRAY_WIDTH_BIT'(LENGTH_HASH_ARRAY);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        REQ,
        FINISH
    } stateT;

    stateT state;
    stateT nextState;

    logic [DATA_INDEX_WIDTH-1:0] hashMem [LENGTH_HASH_ARRAY];
    logic [DATA_INDEX_WIDTH-1:0] occMem  [LENGTH_HASH_ARRAY];

    logic [BIT_ON_TAILS-1:0]     clrCnt;
    logic                        clrLast;
    logic                        startAccept;

    logic [DATA_INDEX_WIDTH-1:0] inHash;
    logic [DATA_INDEX_WIDTH-1:0] inOcc;
    logic [BIT_ON_TAILS-1:0]     drainIdx;
    logic                        addrOk;
    logic [DATA_INDEX_WIDTH-1:0] storedHash;
    logic [DATA_INDEX_WIDTH-1:0] storedOcc;
    logic [DATA_INDEX_WIDTH:0]   sumOcc;
    logic [DATA_INDEX_WIDTH-1:0] satOcc;

    logic                        memWe;
    logic [BIT_ON_TAILS-1:0]     memWaddr;
    logic [DATA_INDEX_WIDTH-1:0] memWhash;
    logic [DATA_INDEX_WIDTH-1:0] memWocc;
    logic                        collInc;
    logic                        addrBad;

    assign clrLast     = &clrCnt;
    assign startAccept = (state == IDLE) && start;
    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);

    // Drain addresses are 1-based; slot k of the table holds address k+1.
    assign inHash     = HashOccurrNext[2*DATA_INDEX_WIDTH-1:DATA_INDEX_WIDTH];
    assign inOcc      = HashOccurrNext[DATA_INDEX_WIDTH-1:0];
    assign drainIdx   = BIT_ON_TAILS'(AddrHashOccurrNext - LENGTH_HASH_ARRAY_WIDTH_BIT'(1));
    assign addrOk     = (AddrHashOccurrNext != '0) && (AddrHashOccurrNext <= MAX_ADDR);
    assign storedHash = hashMem[drainIdx];
    assign storedOcc  = occMem[drainIdx];
    assign sumOcc     = {1'b0, storedOcc} + {1'b0, inOcc};
    assign satOcc     = sumOcc[DATA_INDEX_WIDTH] ? '1 : sumOcc[DATA_INDEX_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = clear ? CLEAR : REQ;
            CLEAR:   if (clrLast) nextState = REQ;
            REQ:     if (CacheEnough) nextState = FINISH;
            FINISH:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Single table write port, shared by the clear sweep and the merge.
    always_comb begin
        memWe    = 1'b0;
        memWaddr = clrCnt;
        memWhash = '0;
        memWocc  = '0;
        collInc  = 1'b0;
        addrBad  = 1'b0;
        if (state == CLEAR) begin
            memWe = 1'b1;
        end else if ((state == REQ) && WrHashNext) begin
            memWaddr = drainIdx;
            if (!addrOk) begin
                addrBad = 1'b1;
            end else if (inOcc == '0) begin
                memWe = 1'b0;
            end else if (storedOcc == '0) begin
                memWe    = 1'b1;
                memWhash = inHash;
                memWocc  = inOcc;
            end else if (storedHash == inHash) begin
                memWe    = 1'b1;
                memWhash = storedHash;
                memWocc  = satOcc;
            end else begin
                // Collision: the heavier entry wins, a tie keeps the resident one.
                collInc  = 1'b1;
                memWe    = (inOcc > storedOcc);
                memWhash = inHash;
                memWocc  = inOcc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clrCnt         <= '0;
            DataRequest    <= 1'b0;
            CollisionCount <= '0;
            AddrError      <= 1'b0;
        end else begin
            DataRequest <= (state == REQ) && (nextState == REQ);
            if (state == CLEAR) begin
                clrCnt <= clrCnt + BIT_ON_TAILS'(1);
            end else begin
                clrCnt <= '0;
            end
            if (startAccept) begin
                CollisionCount <= '0;
                AddrError      <= 1'b0;
            end else begin
                if (collInc && !(&CollisionCount)) begin
                    CollisionCount <= CollisionCount + COLL_CNT_WIDTH'(1);
                end
                if (addrBad) begin
                    AddrError <= 1'b1;
                end
            end
        end
    end

    // NOTE: the table has no reset so it maps onto RAM; a pass with clear=1 initialises it.
    always_ff @(posedge clk) begin
        if (memWe) begin
            hashMem[memWaddr] <= memWhash;
            occMem[memWaddr]  <= memWocc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RdHash   <= '0;
            RdOccurr <= '0;
        end else begin
            RdHash   <= hashMem[RdAddr];
            RdOccurr <= occMem[RdAddr];
        end
    end

endmodule
